fft_stage_sequencer: RTL
========================

# fft_stage_sequencer

Sequencer for an in-place radix-2 decimation-in-time FFT built around the single combinational butterfly unit and a dual-port sample memory. It owns no datapath. It issues one butterfly per cycle, generating:
- read addresses for the even/odd operand pair,
- the twiddle index for the sine/cosine LUT,
- write-back addresses, delayed to match the memory and butterfly pipeline.

It also inserts drain cycles between stages so in-place reads never overtake pending writes. It sits between the top-level control (start/done) and the memory + twiddle LUT + butterfly datapath.

## Interface
- N, 16, FFT points; power of two, N >= 4
- BFLY_LAT, 2, register stages between memory read data and butterfly result (>= 0)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  run request; sampled only in IDLE
- busy  out  1  high from first issue through last write
- done  out  1  one-cycle pulse after final write
- stage  out  $clog2(LOG2N)  stage of the butterfly being issued
- rd_en  out  1  issue strobe: operand read this cycle
- rd_addr_a  out  LOG2N  even-operand address
- rd_addr_b  out  LOG2N  odd-operand address
- tw_idx  out  LOG2N-1  twiddle index k; angle = -2*pi*k/N
- wr_en  out  1  write-back strobe for both results
- wr_addr_a  out  LOG2N  address for Xe+G result
- wr_addr_b  out  LOG2N  address for Xe-G result
- scale  out  1  halve-result flag, aligned with wr_en

## Operation
- Definitions:
  - LOG2N = $clog2(N)
  - LAT = 1 + BFLY_LAT (one cycle memory read latency + butterfly latency)
  - HALF = N/2
- Input data is already in bit-reversed order in memory; loading and unloading are outside this block.
- FSM states:
  - IDLE: start=1 → RUN with s=0, j=0.
  - RUN: assert rd_en. Increment j. At j=HALF-1 → DRAIN with cnt=LAT.
  - DRAIN: count down cnt. At cnt=1: if s=LOG2N-1 → DONE, else s++, j=0 → RUN.
  - DONE: done=1 for one cycle → IDLE.
- Address generation per issue, for stage s and butterfly j:
  - span = 1<<s
  - pos = j & (span-1)
  - grp = j >> s
  - a = grp*2*span + pos
  - b = a + span
  - tw_idx = pos << (LOG2N-1-s)
  - All values are unsigned and exact; no wrap is possible within range.
- Write delay line: a LAT-deep shift register carries {valid, a, b}. wr_en/wr_addr_a/wr_addr_b appear exactly LAT cycles after the matching rd_en.
- The delay line keeps running in DRAIN. The final stage's writes therefore complete before DONE.
- start while busy or in DONE is ignored; it is not queued.
- Reset at any time, including mid-stage:
  - State returns to IDLE.
  - The delay line is cleared, so pending writes are dropped.
  - All outputs go to 0.
- Reset value of every output: 0.

## Timing
- start high at edge E0 → first rd_en in the cycle after E0 (cycle 1).
- Each stage occupies HALF + LAT cycles: HALF issue cycles, then LAT drain cycles.
- The next stage's first read follows its predecessor's last write by one cycle.
- Total busy = LOG2N*(HALF+LAT) cycles. busy is high in cycles 1..LOG2N*(HALF+LAT).
- done is high in the cycle after the last wr_en, with busy low.
- The next start is accepted at the first edge where the state is IDLE, i.e. one cycle after done.
- stage and tw_idx are valid only while rd_en=1; otherwise they hold their last value.
- Memory requirement: a write and a read to the same address in the same cycle never occur.

## Configuration
- FFT_SEQ_SCALE_EN:
  - Defined: scale = wr_en. Every stage result is divided by 2 (block-floating unconditional scaling), giving total gain 1/N.
  - Undefined: scale tied to 0. The datapath grows one bit per stage.

## Structure
- fft_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE),
  - a log2 helper function,
  - an address struct {valid, a, b} used by the delay line.
- Sub-module fft_addr_gen: combinational. Maps (s, j) to (a, b, tw_idx) and is instantiated once.
- The delay line and FSM live in fft_stage_sequencer.

## Test plan
- Reset then idle, N=16: all outputs 0; start held low for 20 cycles → no rd_en.
- N=16, BFLY_LAT=2, start pulse at E0:
  - rd_en in cycles 1..8, 12..19, 23..30, 34..41;
  - wr_en in cycles 4..11, 15..22, 26..33, 37..44;
  - done in cycle 45;
  - busy high in cycles 1..44.
- Addresses, N=16:
  - stage0 j=0 → a=0, b=1, tw=0;
  - stage1 j=1 → a=1, b=3, tw=4;
  - stage2 j=5 → a=9, b=13, tw=2;
  - stage3 j=7 → a=7, b=15, tw=7.
- Across the whole run, each address 0..15 is written exactly once per stage. The wr addresses equal the rd addresses delayed by 3 cycles.
- start re-asserted in cycle 10 mid-run → ignored; the run completes with an unchanged count. start in cycle 46 → a new run whose first rd_en is in cycle 47.
- rst asserted in cycle 13 (stage 1), asynchronously:
  - outputs go to 0 immediately;
  - no wr_en follows;
  - the next start restarts at stage 0, j=0.
  - With FFT_SEQ_SCALE_EN: scale equals wr_en in every cycle. Without it: scale is always 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT stage sequencer: FSM states, a ceil-log2 helper
// and the {valid, a, b} entry carried by the write-back delay line.
package fft_pkg;

    localparam int ADDR_W_MAX = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fft_state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_MAX-1:0] a;
        logic [ADDR_W_MAX-1:0] b;
    } fft_addr_t;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage s, butterfly j) ->
// even/odd operand addresses and twiddle index.
module fft_addr_gen #(
    parameter int LOG2N = 4,
    parameter int SW    = 2
) (
    input  logic [SW-1:0]    i_s,
    input  logic [LOG2N-2:0] i_j,
    output logic [LOG2N-1:0] o_a,
    output logic [LOG2N-1:0] o_b,
    output logic [LOG2N-2:0] o_tw
);

    localparam int            JW   = LOG2N - 1;
    localparam logic [SW-1:0] JW_S = SW'(JW);

    logic [JW-1:0] w_mask;
    logic [JW-1:0] w_pos;
    logic [JW-1:0] w_grp;
    logic [SW-1:0] w_tw_sh;

    // At the last stage 1<<s overflows to 0 in JW bits, so the mask becomes all ones.
    assign w_mask  = (JW'(1) << i_s) - JW'(1);
    assign w_pos   = i_j & w_mask;
    assign w_grp   = i_j >> i_s;
    assign w_tw_sh = JW_S - i_s;

    assign o_a  = (({1'b0, w_grp} << i_s) << 1) | {1'b0, w_pos};
    assign o_b  = o_a | (LOG2N'(1) << i_s);
    assign o_tw = w_pos << w_tw_sh;

endmodule

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIT FFT sequencer: one butterfly issue per cycle, LAT-deep
// write-back delay line, drain between stages. FFT_SEQ_SCALE_EN drives scale = wr_en.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter  int N        = 16,
    parameter  int BFLY_LAT = 2,
    localparam int LOG2N    = log2c(N),
    localparam int SW       = log2c(LOG2N),
    localparam int JW       = LOG2N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [JW-1:0]    tw_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic             scale
);

    localparam int LAT  = 1 + BFLY_LAT;
    localparam int HALF = N / 2;
    localparam int CW   = log2c(LAT + 1);

    fft_state_t       r_state, w_state_nx;
    logic [SW-1:0]    r_s, w_s_nx;
    logic [JW-1:0]    r_j, w_j_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             w_rd_en, w_busy, w_done;
    logic [LOG2N-1:0] w_a, w_b;
    logic [JW-1:0]    w_tw;
    fft_addr_t        r_dly [LAT];
    fft_addr_t        w_head, w_tail;
    logic             w_unused;

    fft_addr_gen #(.LOG2N(LOG2N), .SW(SW)) u_addr_gen (
        .i_s  (r_s),
        .i_j  (r_j),
        .o_a  (w_a),
        .o_b  (w_b),
        .o_tw (w_tw)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_j     <= w_j_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // s and j hold outside RUN so stage/tw_idx keep their last issued value.
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_j_nx     = r_j;
        w_cnt_nx   = r_cnt;
        w_rd_en    = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = RUN;
                    w_s_nx     = '0;
                    w_j_nx     = '0;
                end
            end
            RUN: begin
                w_rd_en = 1'b1;
                w_busy  = 1'b1;
                if (r_j == JW'(HALF - 1)) begin
                    w_state_nx = DRAIN;
                    w_cnt_nx   = CW'(LAT);
                end else begin
                    w_j_nx = r_j + JW'(1);
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    if (r_s == SW'(LOG2N - 1)) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = RUN;
                        w_s_nx     = r_s + SW'(1);
                        w_j_nx     = '0;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CW'(1);
                end
            end
            DONE: begin
                w_done     = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_head = '0;
        if (w_rd_en) begin
            w_head.valid = 1'b1;
            w_head.a     = ADDR_W_MAX'(w_a);
            w_head.b     = ADDR_W_MAX'(w_b);
        end
    end

    // Keeps shifting in DRAIN so the final stage's writes land before DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= w_head;
            for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
        end
    end

    assign w_tail   = r_dly[LAT-1];
    assign w_unused = ^{w_tail.a[ADDR_W_MAX-1:LOG2N], w_tail.b[ADDR_W_MAX-1:LOG2N]};

    assign busy      = w_busy;
    assign done      = w_done;
    assign stage     = r_s;
    assign rd_en     = w_rd_en;
    assign rd_addr_a = w_rd_en ? w_a : '0;
    assign rd_addr_b = w_rd_en ? w_b : '0;
    assign tw_idx    = w_tw;
    assign wr_en     = w_tail.valid;
    assign wr_addr_a = w_tail.a[LOG2N-1:0];
    assign wr_addr_b = w_tail.b[LOG2N-1:0];

`ifdef FFT_SEQ_SCALE_EN
    assign scale = w_tail.valid;
`else
    assign scale = 1'b0;
`endif

endmodule
